// File: rtl/fbs_pkg.sv
// Shared types and address helper for the frame-buffer scheduler.
package fbs_pkg;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_state_t;

  typedef enum logic {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_fsm_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_ACTIVE = 1'b1
  } rd_fsm_t;

  // Only ever called with elaboration constants, so the multiply folds away.
  function automatic logic [31:0] buf_addr(input logic [31:0] base,
                                           input logic [31:0] frame_bytes,
                                           input int unsigned idx);
    return base + frame_bytes * 32'(idx);
  endfunction

endpackage

// File: rtl/fbs_pick.sv
// Finds the lowest-index buffer whose 2-bit state equals the target state.
module fbs_pick #(
  parameter int NUM_BUFS = 3,
  parameter int IDX_W    = 2
) (
  input  logic [2*NUM_BUFS-1:0] state_vec,
  input  logic [1:0]            target,
  output logic                  found,
  output logic [IDX_W-1:0]      idx
);

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (state_vec[2*i +: 2] == target) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer ring arbiter between the camera writer and the LCD reader:
// hands out free buffers, publishes the newest frame and counts dropped frames.
module frame_buffer_scheduler
  import fbs_pkg::*;
#(
  parameter int          NUM_BUFS    = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'd153600,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr_req,
  output logic             wr_grant,
  output logic [31:0]      wr_addr,
  input  logic             wr_done,
  input  logic             rd_req,
  output logic             rd_grant,
  output logic [31:0]      rd_addr,
  input  logic             rd_done,
  output logic             frame_rdy_irq,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int IDX_W = $clog2(NUM_BUFS);

  if (NUM_BUFS < 3) begin : g_num_bufs_check
    $error("frame_buffer_scheduler: NUM_BUFS must be >= 3");
  end

  logic [31:0] addr_tab_s [NUM_BUFS];
  for (genvar gi = 0; gi < NUM_BUFS; gi++) begin : g_addr
    assign addr_tab_s[gi] = buf_addr(BASE_ADDR, FRAME_BYTES, gi);
  end

  buf_state_t           buf_state_r [NUM_BUFS];
  buf_state_t           buf_next_s  [NUM_BUFS];
  logic [2*NUM_BUFS-1:0] state_vec_s;
  wr_fsm_t              wr_state_r, wr_next_s;
  rd_fsm_t              rd_state_r, rd_next_s;
  logic                 free_found_s, ready_found_s;
  logic [IDX_W-1:0]     free_idx_s, ready_idx_s;
  logic                 wr_take_s, wr_fin_s, rd_take_s, rd_fin_s, drop_s;
  logic                 wr_grant_r, rd_grant_r, irq_r;
  logic [31:0]          wr_addr_r, rd_addr_r;
  logic [CNT_W-1:0]     drop_r;

  // Flatten registered buffer states for the two pickers.
  always_comb begin
    state_vec_s = {2*NUM_BUFS{1'b0}};
    for (int i = 0; i < NUM_BUFS; i++) begin
      state_vec_s[2*i +: 2] = buf_state_r[i];
    end
  end

  fbs_pick #(.NUM_BUFS(NUM_BUFS), .IDX_W(IDX_W)) u_pick_free (
    .state_vec (state_vec_s),
    .target    (BUF_FREE),
    .found     (free_found_s),
    .idx       (free_idx_s)
  );

  fbs_pick #(.NUM_BUFS(NUM_BUFS), .IDX_W(IDX_W)) u_pick_ready (
    .state_vec (state_vec_s),
    .target    (BUF_READY),
    .found     (ready_found_s),
    .idx       (ready_idx_s)
  );

  // Writer/reader FSM decisions and per-buffer next state.
  always_comb begin
    wr_take_s = (wr_state_r == W_IDLE) && wr_req && enable && free_found_s;
    wr_fin_s  = (wr_state_r == W_ACTIVE) && wr_done;
    rd_take_s = (rd_state_r == R_IDLE) && rd_req && enable && ready_found_s;
    rd_fin_s  = (rd_state_r == R_ACTIVE) && rd_done;
    // A READY buffer is dropped only if the reader is not claiming it this cycle.
    drop_s    = wr_fin_s && ready_found_s && !rd_take_s;

    wr_next_s = wr_state_r;
    if (wr_take_s) begin
      wr_next_s = W_ACTIVE;
    end else if (wr_fin_s) begin
      wr_next_s = W_IDLE;
    end else begin
      wr_next_s = wr_state_r;
    end

    rd_next_s = rd_state_r;
    if (rd_take_s) begin
      rd_next_s = R_ACTIVE;
    end else if (rd_fin_s) begin
      rd_next_s = R_IDLE;
    end else begin
      rd_next_s = rd_state_r;
    end

    for (int i = 0; i < NUM_BUFS; i++) begin
      buf_next_s[i] = buf_state_r[i];
      case (buf_state_r[i])
        BUF_FREE: begin
          if (wr_take_s && (free_idx_s == IDX_W'(i))) buf_next_s[i] = BUF_WRITING;
          else                                       buf_next_s[i] = BUF_FREE;
        end
        BUF_WRITING: begin
          if (wr_fin_s) buf_next_s[i] = BUF_READY;
          else          buf_next_s[i] = BUF_WRITING;
        end
        BUF_READY: begin
          if (rd_take_s && (ready_idx_s == IDX_W'(i))) buf_next_s[i] = BUF_READING;
          else if (wr_fin_s)                          buf_next_s[i] = BUF_FREE;
          else                                        buf_next_s[i] = BUF_READY;
        end
        BUF_READING: begin
          if (rd_fin_s) buf_next_s[i] = BUF_FREE;
          else          buf_next_s[i] = BUF_READING;
        end
        default: buf_next_s[i] = BUF_FREE;
      endcase
    end
  end

  // State, grant, address, interrupt and drop-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUFS; i++) buf_state_r[i] <= BUF_FREE;
      wr_state_r <= W_IDLE;
      rd_state_r <= R_IDLE;
      wr_grant_r <= 1'b0;
      rd_grant_r <= 1'b0;
      wr_addr_r  <= BASE_ADDR;
      rd_addr_r  <= BASE_ADDR;
      irq_r      <= 1'b0;
      drop_r     <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_BUFS; i++) buf_state_r[i] <= buf_next_s[i];
      wr_state_r <= wr_next_s;
      rd_state_r <= rd_next_s;
      wr_grant_r <= wr_take_s;
      rd_grant_r <= rd_take_s;
      wr_addr_r  <= wr_take_s ? addr_tab_s[free_idx_s] : wr_addr_r;
      rd_addr_r  <= rd_take_s ? addr_tab_s[ready_idx_s] : rd_addr_r;
      irq_r      <= wr_fin_s ? 1'b1 : (irq_ack ? 1'b0 : irq_r);
      if (drop_s && (drop_r != {CNT_W{1'b1}})) drop_r <= drop_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else                                     drop_r <= drop_r;
    end
  end

  assign wr_grant      = wr_grant_r;
  assign rd_grant      = rd_grant_r;
  assign wr_addr       = wr_addr_r;
  assign rd_addr       = rd_addr_r;
  assign frame_rdy_irq = irq_r;
  assign drop_cnt      = drop_r;

endmodule
